// File: rtl/byte_serial_instr_fetch.sv
// Byte-serial instruction fetch: reads one byte per cycle and assembles big-endian 32-bit words for decode.
// Optional handshake counter output fetch_cnt is enabled by defining FETCH_CNT_EN.
module byte_serial_instr_fetch #(
  parameter int ADDR_W    = 32,
  parameter int INSTR_MAX = 128,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
`ifdef FETCH_CNT_EN
  output logic [15:0]       fetch_cnt,
`endif
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] memLimit = ADDR_W'(INSTR_MAX);
  localparam logic [ADDR_W-1:0] startPc  = ADDR_W'(RESET_PC);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        cnt;
  logic [23:0]       shiftBuf;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] redirTarget;
  logic              fetching;

  assign pcPlus4     = pc + ADDR_W'(4);
  assign redirTarget = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign fetching    = (state == FETCH) && (cnt != 3'd4);

  assign mem_en      = fetching;
  assign mem_addr    = fetching ? (pc + ADDR_W'(cnt)) : '0;
  assign instr_valid = (state == HOLD);
  assign done        = (state == DONE);

  // Only the first three bytes are buffered; the fourth arrives in the cnt=4 cycle and goes straight into instr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= startPc;
      cnt      <= 3'd0;
      shiftBuf <= '0;
      instr    <= '0;
      instr_pc <= '0;
`ifdef FETCH_CNT_EN
      fetch_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= FETCH;
            pc       <= startPc;
            cnt      <= 3'd0;
            shiftBuf <= '0;
`ifdef FETCH_CNT_EN
            fetch_cnt <= '0;
`endif
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc       <= redirTarget;
            cnt      <= 3'd0;
            shiftBuf <= '0;
            state    <= (redirTarget >= memLimit) ? DONE : FETCH;
          end else if (cnt == 3'd4) begin
            instr    <= {shiftBuf, mem_rdata};
            instr_pc <= pc;
            cnt      <= 3'd0;
            state    <= HOLD;
          end else begin
            if (cnt != 3'd0) begin
              shiftBuf <= {shiftBuf[15:0], mem_rdata};
            end
            cnt <= cnt + 3'd1;
          end
        end
        HOLD: begin
`ifdef FETCH_CNT_EN
          if (instr_ready) begin
            fetch_cnt <= fetch_cnt + 16'd1;
          end
`endif
          // A redirect coinciding with acceptance still consumes the instruction but overrides pc+4.
          if (redirect_valid) begin
            pc       <= redirTarget;
            cnt      <= 3'd0;
            shiftBuf <= '0;
            state    <= (redirTarget >= memLimit) ? DONE : FETCH;
          end else if (instr_ready) begin
            pc       <= pcPlus4;
            cnt      <= 3'd0;
            shiftBuf <= '0;
            state    <= (pcPlus4 >= memLimit) ? DONE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_instr_fetch.sv
// Directed testbench for byte_serial_instr_fetch with a synchronous-read byte memory model.
module tb_byte_serial_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        done;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  logic [7:0] mem [0:127];
  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  byte_serial_instr_fetch #(.ADDR_W(32), .INSTR_MAX(128), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
`ifdef FETCH_CNT_EN
    .fetch_cnt(fetch_cnt),
`endif
    .done(done)
  );

  // Synchronous-read memory; out-of-range reads return a recognisable poison byte.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 8'hEE;
  end

  function automatic logic [31:0] wordAt(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (instr_valid) ok = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if ({mem_en, mem_addr, instr, instr_pc, instr_valid, done} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: en=%b addr=%h instr=%h pc=%h v=%b done=%b, expected all 0",
               mem_en, mem_addr, instr, instr_pc, instr_valid, done);
    end
  endtask

  task automatic test_basic_and_backpressure();
    logic [31:0] heldInstr;
    doReset();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      testsRun++;
      if (mem_en !== 1'b1 || mem_addr !== 32'(k)) begin
        testsFailed++;
        $display("[TB] FAIL basic_addr%0d: en=%b addr=%h, expected en=1 addr=%h", k, mem_en, mem_addr, k);
      end
      tick();
    end
    testsRun++;
    if (mem_en !== 1'b0 || instr_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_cnt4: en=%b v=%b, expected 0 0", mem_en, instr_valid);
    end
    tick();
    testsRun++;
    if (instr_valid !== 1'b1 || instr !== 32'h012A4020 || instr_pc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL basic_instr: v=%b instr=%h pc=%h, expected 1 012a4020 0", instr_valid, instr, instr_pc);
    end
    heldInstr = 32'h012A4020;
    for (int k = 0; k < 3; k++) begin
      tick();
      testsRun++;
      if (instr_valid !== 1'b1 || instr !== heldInstr || instr_pc !== 32'h0 || mem_en !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL backpressure_hold%0d: v=%b instr=%h pc=%h en=%b, expected 1 %h 0 0",
                 k, instr_valid, instr, instr_pc, mem_en, heldInstr);
      end
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    testsRun++;
    if (instr_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h4) begin
      testsFailed++;
      $display("[TB] FAIL backpressure_accept: v=%b en=%b addr=%h, expected 0 1 4", instr_valid, mem_en, mem_addr);
    end
  endtask

  task automatic test_full_run();
    int accepts = 0;
    int expPc = 0;
    bit badAddr = 1'b0;
    bit lastSeen = 1'b0;
    bit doneOk = 1'b0;
    doReset();
    instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (mem_en && mem_addr >= 32'd128) badAddr = 1'b1;
      if (instr_valid) begin
        testsRun++;
        if (instr_pc !== 32'(expPc) || instr !== wordAt(expPc)) begin
          testsFailed++;
          $display("[TB] FAIL full_instr: pc=%h instr=%h, expected pc=%h instr=%h", instr_pc, instr, expPc, wordAt(expPc));
        end
        lastSeen = (expPc == 124);
        accepts++;
        expPc += 4;
        tick();
        if (lastSeen) doneOk = (done === 1'b1);
      end else begin
        tick();
      end
    end
    instr_ready = 1'b0;
    testsRun++;
    if (accepts != 32 || !doneOk || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL full_count: accepts=%0d done_after_last=%b done=%b, expected 32 1 1", accepts, doneOk, done);
    end
    testsRun++;
    if (badAddr) begin
      testsFailed++;
      $display("[TB] FAIL full_addr_range: mem_en seen with addr>=128, expected never");
    end
  endtask

  task automatic test_redirect();
    bit ok;
    doReset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_addr = 32'h41;
    tick();
    redirect_valid = 1'b0;
    testsRun++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      testsFailed++;
      $display("[TB] FAIL redirect_addr: en=%b addr=%h, expected 1 40", mem_en, mem_addr);
    end
    waitValid(10, ok);
    testsRun++;
    if (!ok || instr_pc !== 32'h40 || instr !== wordAt(32'h40)) begin
      testsFailed++;
      $display("[TB] FAIL redirect_instr: ok=%b pc=%h instr=%h, expected 1 40 %h", ok, instr_pc, instr, wordAt(32'h40));
    end
    redirect_valid = 1'b1; redirect_addr = 32'h80;
    tick();
    redirect_valid = 1'b0;
    testsRun++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || mem_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL redirect_done: done=%b v=%b en=%b, expected 1 0 0", done, instr_valid, mem_en);
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    doReset();
    instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waitValid(10, ok);
      if (k < 2) tick();
    end
    testsRun++;
    if (!ok || instr_pc !== 32'h8) begin
      testsFailed++;
      $display("[TB] FAIL rh_reach8: ok=%b pc=%h, expected 1 8", ok, instr_pc);
    end
    redirect_valid = 1'b1; redirect_addr = 32'h20;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    testsRun++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'h20) begin
      testsFailed++;
      $display("[TB] FAIL rh_next_addr: v=%b addr=%h, expected 0 20", instr_valid, mem_addr);
    end
`ifdef FETCH_CNT_EN
    testsRun++;
    if (fetch_cnt !== 16'd3) begin
      testsFailed++;
      $display("[TB] FAIL rh_fetch_cnt: got %0d, expected 3", fetch_cnt);
    end
`endif
    waitValid(10, ok);
    testsRun++;
    if (!ok || instr_pc !== 32'h20 || instr !== wordAt(32'h20)) begin
      testsFailed++;
      $display("[TB] FAIL rh_instr: ok=%b pc=%h instr=%h, expected 1 20 %h", ok, instr_pc, instr, wordAt(32'h20));
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    doReset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    testsRun++;
    if (mem_addr !== 32'h3) begin
      testsFailed++;
      $display("[TB] FAIL midreset_cnt3: addr=%h, expected 3", mem_addr);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    testsRun++;
    if ({mem_en, mem_addr, instr, instr_pc, instr_valid, done} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: en=%b addr=%h instr=%h pc=%h v=%b done=%b, expected all 0",
               mem_en, mem_addr, instr, instr_pc, instr_valid, done);
    end
    tick(); tick(); tick(); tick(); tick(); tick();
    testsRun++;
    if (instr_valid !== 1'b0 || mem_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_idle: v=%b en=%b, expected 0 0", instr_valid, mem_en);
    end
    start = 1'b1; tick(); start = 1'b0;
    waitValid(6, ok);
    testsRun++;
    if (!ok || instr_pc !== 32'h0 || instr !== 32'h012A4020) begin
      testsFailed++;
      $display("[TB] FAIL midreset_restart: ok=%b pc=%h instr=%h, expected 1 0 012a4020", ok, instr_pc, instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    mem[0] = 8'h01; mem[1] = 8'h2A; mem[2] = 8'h40; mem[3] = 8'h20;
    mem_rdata = '0;
    test_reset();
    test_basic_and_backpressure();
    test_full_run();
    test_redirect();
    test_redirect_handshake();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
